muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) and produces the 64-bit result in architectural HI/LO registers.
- Supports MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are readable at all times for MFHI/MFLO.
- Uses an iterative shift-add multiplier and a restoring divider: one result bit per cycle.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULDIV_EARLY_EXIT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   raw_a;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               is_sgn;
  logic               sign_a;
  logic               sign_b;
  logic               div0;

  logic               sgn_req;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_quo;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   nxt_acc;
  logic [WIDTH-1:0]   nxt_quo;
  logic               to_fix;
  logic               last;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
`ifdef MULDIV_EARLY_EXIT_EN
  logic [WIDTH-1:0]   ee_mask;
  logic [CNT_W-1:0]   ee_sh;
  logic [2*WIDTH-1:0] ee_pair;
`endif

  // Operand conversion, one iteration step and final sign fix-up
  always_comb begin
    sgn_req = ~op[0];
    a_mag   = (sgn_req & op_a[WIDTH-1]) ? -op_a : op_a;
    b_mag   = (sgn_req & op_b[WIDTH-1]) ? -op_b : op_b;

    mul_sum = {1'b0, acc} + {1'b0, (quo[0] ? dvs : '0)};
    mul_acc = mul_sum[WIDTH:1];
    mul_quo = {mul_sum[0], quo[WIDTH-1:1]};

    rem_sh  = {acc, quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs};

    last    = (cnt == CNT_W'(WIDTH - 1));
    nxt_acc = mul_acc;
    nxt_quo = mul_quo;
    to_fix  = last;

    if (is_div) begin
      nxt_acc = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      nxt_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
`ifdef MULDIV_EARLY_EXIT_EN
    ee_mask = {WIDTH{1'b1}} >> (cnt + 1'b1);
    ee_sh   = CNT_W'(WIDTH - 1) - cnt;
    ee_pair = {mul_acc, mul_quo} >> ee_sh;
    if (!is_div && ((mul_quo & ee_mask) == '0)) begin
      nxt_acc = ee_pair[2*WIDTH-1:WIDTH];
      nxt_quo = ee_pair[WIDTH-1:0];
      to_fix  = 1'b1;
    end
`endif

    prod     = {acc, quo};
    prod_fix = (is_sgn & (sign_a ^ sign_b)) ? -prod : prod;
    q_fix    = (is_sgn & (sign_a ^ sign_b)) ? -quo : quo;
    r_fix    = (is_sgn & sign_a) ? -acc : acc;
  end

  // Control FSM, datapath and HI/LO registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      quo    <= '0;
      dvs    <= '0;
      raw_a  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            is_sgn <= sgn_req;
            sign_a <= sgn_req & op_a[WIDTH-1];
            sign_b <= sgn_req & op_b[WIDTH-1];
            div0   <= (op_b == '0);
            raw_a  <= op_a;
            acc    <= '0;
            quo    <= op[1] ? a_mag : b_mag;
            dvs    <= op[1] ? b_mag : a_mag;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (mthi) hi <= op_a;
            if (mtlo) lo <= op_a;
          end
        end
        CALC: begin
          acc <= nxt_acc;
          quo <= nxt_quo;
          cnt <= cnt + 1'b1;
          if (to_fix) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div0) begin
            hi <= raw_a;
            lo <= '1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and model-based checks for muldiv_unit.
// Expected results go through a scoreboard queue popped on done.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  op;
  logic        start;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clk),
    .reset(rst_n),
    .op_a (op_a),
    .op_b (op_b),
    .op   (op),
    .start(start),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb2;
    longint unsigned ua;
    longint unsigned ub;
    int q;
    int r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    res = '0;
    if (o == 2'd0) res = sa * sb2;
    else if (o == 2'd1) res = ua * ub;
    else if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
    else if (o == 2'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
      else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        res = {r, q};
      end
    end else res = {a % b, a / b};
    return res;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int h;
    h = 0;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      logic [31:0] m;
      m = o[0] ? b : ($signed(b) < 0 ? -b : b);
      for (int i = 0; i < 32; i++) if (m[i]) h = i;
      return h + 2;
    end
`endif
    return 33 + h;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input logic mv);
    int lat;
    logic [63:0] e;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1; mthi = mv;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk({tag, "_busy"}, {63'h0, busy}, 64'h1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      chk({tag, "_timeout"}, 64'(lat), 64'h0);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, b)));
      chk({tag, "_res"}, {hi, lo}, e);
      chk({tag, "_busy_low"}, {63'h0, busy}, 64'h0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [63:0] e;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_busy_done", {62'h0, busy, done}, 64'h0);
    rst_n = 1'b1;

    run_op("multu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);

    @(negedge clk);
    op_a = 32'h1234_5678; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi", {hi, lo}, 64'h1234_5678_8000_0000);
    chk("mthi_nodone", {63'h0, done}, 64'h0);
    op_a = 32'hCAFE_F00D; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

    op = 2'd3; op_a = 32'd50; op_b = 32'd7; start = 1'b1;
    sb.push_back(64'h0000_0001_0000_0007);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = 2'd1; op_a = 32'hAA; op_b = 32'd3; start = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("ign_hold", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
    chk("ign_busy", {63'h0, busy}, 64'h1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("ign_res", {hi, lo}, e);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_one_done", 64'(ndone), 64'h0);

    run_op("start_mthi", 2'd1, 32'd2, 32'd3, 64'd6, 1'b1);

    for (int i = 0; i < 6; i++) begin
      ro = 2'(i % 4);
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom;
      if (i == 2) rb = rb >> 20;
      run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    run_op("multu_5x1", 2'd1, 32'd5, 32'd1, 64'd5, 1'b0);
    run_op("multu_5xmsb", 2'd1, 32'd5, 32'h8000_0000, 64'h0000_0002_8000_0000, 1'b0);

    @(negedge clk);
    op = 2'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", 64'(ndone), 64'h0);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
